painterengine_gpu_dma_reader: RTL and testbench
===============================================

# painterengine_gpu_dma_reader

AXI4 read-master DMA stage that sits directly upstream of the GPU DMA writer. It fetches a word-aligned region of memory in bounded INCR bursts and buffers the beats in an internal FIFO. It presents them as a 32-bit valid/next stream that plugs straight into one writer data lane (`i_wire_data[k]`, `i_wire_data_valid[k]`, `o_wire_data_next[k]`). It reports done and error with the same conventions as the writer.

## Interface
- PARAM_BURST_MAX, 16: maximum beats per AR burst; power of two, 1..256.
- PARAM_FIFO_LOG2, 5: log2 of FIFO depth in words; depth must be ≥ PARAM_BURST_MAX.
- i_wire_clock  in  1  clock.
- i_wire_resetn  in  1  reset, asynchronous, active-low.
- i_wire_start  in  1  one-cycle pulse; accepted only in IDLE, DONE or any error state.
- i_wire_address  in  32  byte start address; must be 4-byte aligned.
- i_wire_length  in  32  transfer length in 32-bit words; must be nonzero.
- o_wire_done  out  1  high while in DONE.
- o_wire_error  out  1  high while in any error state.
- o_wire_error_type  out  3  0 ok, 1 address align, 2 zero length, 3 AR timeout, 4 R timeout, 5 RRESP error, 6 RLAST mismatch.
- o_wire_data  out  32  FIFO head word.
- o_wire_data_valid  out  1  FIFO non-empty.
- i_wire_data_next  in  1  consumer took the head word this cycle; ignored when valid is low.
- o_wire_M_AXI_ARID, ARADDR[31:0], ARLEN[7:0], ARSIZE[2:0], ARBURST[1:0], ARLOCK, ARCACHE[3:0], ARPROT[2:0], ARQOS[3:0], ARVALID  out: AXI read-address channel. Constants: ID 0, SIZE 3'b010, BURST 2'b01, LOCK 0, CACHE 4'b0010, PROT 0, QOS 0.
- i_wire_M_AXI_ARREADY  in  1.
- i_wire_M_AXI_RID[0:0], RDATA[31:0], RRESP[1:0], RLAST, RVALID  in: AXI read-data channel.
- o_wire_M_AXI_RREADY  out  1.

## Operation
- State encoding (5 bits; bit 4 set means error):
  - IDLE=01, CHECK=02, CALC=03, CALC2=04, ADDR=05, DATA=06, DRAIN=07, DONE=08.
  - Error states: ALIGN_ERR=11, LEN_ERR=12, AR_ERR=13, R_ERR=14, RESP_ERR=15, LAST_ERR=16.
- IDLE/DONE/ERR + start: latch address and length, clear the offset, go to CHECK. A start pulse in any other state is ignored.
- CHECK: `address[1:0]!=0` goes to ALIGN_ERR. Otherwise length==0 goes to LEN_ERR. Otherwise go to CALC.
- CALC:
  - remaining = length − offset.
  - boundary = 256 − ((address + 4·offset)[9:2]) (9-bit).
  - Go to CALC2.
- CALC2:
  - burst = min(remaining, boundary, PARAM_BURST_MAX).
  - If FIFO free ≥ burst, go to ADDR. Otherwise stay in CALC2, recomputing each cycle.
- ADDR:
  - Drive ARADDR = address + 4·offset, ARLEN = burst−1, ARVALID=1.
  - ARADDR/ARLEN stay stable while ARVALID is high.
  - On ARREADY: drop ARVALID, clear the beat counter, go to DATA.
- DATA:
  - RREADY=1. Each RVALID beat is pushed into the FIFO and increments the beat counter.
  - RRESP ≥ 2'b10 on any beat: push the beat, then go to RESP_ERR.
  - RLAST asserted on a beat whose index is not burst−1, or deasserted on beat burst−1: go to LAST_ERR.
  - After the final beat: offset += burst. If offset ≥ length go to DRAIN, else go to CALC.
- DRAIN: wait for the FIFO to empty, then go to DONE.
- DONE and error states are sticky until the next start or reset.
- FIFO:
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Pop happens on `i_wire_data_next && o_wire_data_valid`.
  - Overflow is impossible by construction, because the burst is only issued when free ≥ burst.
- Arithmetic: all 32-bit, wrap ignored. length·4 + address overflow is undefined; software guarantees it does not occur.

## Timing
- Reset values:
  - state IDLE; ARVALID 0; RREADY 0; ARADDR 0; ARLEN 0.
  - FIFO empty, so data_valid 0 and o_wire_data 0.
  - done 0; error 0; error_type 0.
- start → first ARVALID: 4 cycles minimum (CHECK, CALC, CALC2, ADDR registered).
- RREADY is combinational with state==DATA. Beats push one per cycle with no bubbles.
- FIFO push → o_wire_data_valid: 1 cycle (registered count). o_wire_data is valid in the same cycle as valid.
- Between bursts there are at least 3 idle cycles on AR (CALC, CALC2, ADDR).
- Reset mid-burst: all state cleared asynchronously, FIFO flushed. Outstanding AXI beats after reset are the interconnect's concern.

## Configuration
- PAINTERENGINE_GPU_READER_TIMEOUT_EN:
  - Defined: a 16-bit watchdog counts consecutive stalled cycles in ADDR (ARREADY low) and in DATA (RVALID low).
  - It resets on every handshake. Reaching 256 goes to AR_ERR (type 3) or R_ERR (type 4).
  - Not defined: the watchdog is absent, the block waits indefinitely, and types 3/4 are never produced.

## Structure
- The shared package `painterengine_gpu_pkg` holds:
  - state localparams and error-type codes;
  - the AXI constant values (SIZE, BURST, CACHE);
  - the timeout limit 256.
- The writer uses the same package.
- One sub-module, `painterengine_gpu_sync_fifo` (WIDTH, LOG2 params; push/pop/full/empty/count), which the writer-side skid buffers will reuse.

## Test plan
- addr 0x1000, len 8, ARREADY/RVALID always high, next always high: exactly one AR (ARADDR 0x1000, ARLEN 7). The 8 words stream out in order, then done=1.
- addr 0x13F8 (2 words before the 1 KB boundary), len 20, BURST_MAX 16: ARs (0x13F8, LEN 1), (0x1400, LEN 15), (0x1440, LEN 1).
- len 64 with next held low: at most 32 words buffered, no AR while free < 16. Releasing next resumes the bursts, and all 64 words arrive in order.
- addr 0x1002: error=1, error_type=1, no ARVALID. Then start with addr 0x1000, len 0: error_type=2.
- Third beat returns RRESP=2'b10: error_type=5, RREADY drops. RLAST on beat 2 of a 4-beat burst: error_type=6.
- Reset asserted mid-DATA: all outputs return to reset values immediately. With TIMEOUT_EN defined, ARREADY held low for 256 cycles gives error_type=3.

Source files
------------

// File: rtl/painterengine_gpu_pkg.sv
// Shared definitions for the PainterEngine GPU DMA reader and writer:
// state encodings (bit 4 marks an error state), error-type codes,
// fixed AXI attribute values and the watchdog limit.
package painterengine_gpu_pkg;

   typedef logic [4:0] gpu_state_t;

   localparam gpu_state_t ST_IDLE      = 5'h01;
   localparam gpu_state_t ST_CHECK     = 5'h02;
   localparam gpu_state_t ST_CALC      = 5'h03;
   localparam gpu_state_t ST_CALC2     = 5'h04;
   localparam gpu_state_t ST_ADDR      = 5'h05;
   localparam gpu_state_t ST_DATA      = 5'h06;
   localparam gpu_state_t ST_DRAIN     = 5'h07;
   localparam gpu_state_t ST_DONE      = 5'h08;
   localparam gpu_state_t ST_ALIGN_ERR = 5'h11;
   localparam gpu_state_t ST_LEN_ERR   = 5'h12;
   localparam gpu_state_t ST_AR_ERR    = 5'h13;
   localparam gpu_state_t ST_R_ERR     = 5'h14;
   localparam gpu_state_t ST_RESP_ERR  = 5'h15;
   localparam gpu_state_t ST_LAST_ERR  = 5'h16;

   localparam logic [2:0] ERR_NONE  = 3'd0;
   localparam logic [2:0] ERR_ALIGN = 3'd1;
   localparam logic [2:0] ERR_LEN   = 3'd2;
   localparam logic [2:0] ERR_AR    = 3'd3;
   localparam logic [2:0] ERR_R     = 3'd4;
   localparam logic [2:0] ERR_RESP  = 3'd5;
   localparam logic [2:0] ERR_LAST  = 3'd6;

   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [3:0] AXI_CACHE_MOD  = 4'b0010;

   localparam logic [15:0] TIMEOUT_LIMIT = 16'd256;

   // Error states are exactly those with bit 4 set.
   function automatic logic state_is_error(input gpu_state_t s);
      return s[4];
   endfunction

endpackage

// File: rtl/painterengine_gpu_sync_fifo.sv
// Single-clock FIFO of 2**LOG2 words. Simultaneous push and pop are both
// honoured. The head word reads as zero while the FIFO is empty.
module painterengine_gpu_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int LOG2  = 5
) (
   input  logic             i_wire_clock,
   input  logic             i_wire_resetn,
   input  logic             i_wire_push,
   input  logic [WIDTH-1:0] i_wire_push_data,
   input  logic             i_wire_pop,
   output logic [WIDTH-1:0] o_wire_pop_data,
   output logic             o_wire_full,
   output logic             o_wire_empty,
   output logic [LOG2:0]    o_wire_count
);

   localparam logic [LOG2:0]   DEPTH_C   = {1'b1, {LOG2{1'b0}}};
   localparam logic [LOG2-1:0] PTR_ONE_C = LOG2'(1);
   localparam logic [LOG2:0]   CNT_ONE_C = (LOG2+1)'(1);

   logic [WIDTH-1:0] mem_r [0:(1<<LOG2)-1];
   logic [LOG2-1:0]  wr_ptr_r;
   logic [LOG2-1:0]  rd_ptr_r;
   logic [LOG2:0]    count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign o_wire_full     = (count_r == DEPTH_C);
   assign o_wire_empty    = (count_r == {(LOG2+1){1'b0}});
   assign o_wire_count    = count_r;
   assign push_ok_s       = i_wire_push && !o_wire_full;
   assign pop_ok_s        = i_wire_pop && !o_wire_empty;
   assign o_wire_pop_data = o_wire_empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

   // Storage array write port; contents need no reset.
   always_ff @(posedge i_wire_clock) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= i_wire_push_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         wr_ptr_r <= {LOG2{1'b0}};
         rd_ptr_r <= {LOG2{1'b0}};
         count_r  <= {(LOG2+1){1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_ONE_C;
            2'b01:   count_r <= count_r - CNT_ONE_C;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/painterengine_gpu_dma_reader.sv
// AXI4 read-master DMA stage feeding one GPU DMA writer data lane.
// Fetches a word-aligned region in INCR bursts that never cross a 1 KB
// boundary, are capped at PARAM_BURST_MAX beats and are only issued when
// the FIFO has room for the whole burst.
// Optional feature: define PAINTERENGINE_GPU_READER_TIMEOUT_EN to enable
// the AR/R stall watchdog (error types 3 and 4).
module painterengine_gpu_dma_reader
   import painterengine_gpu_pkg::*;
#(
   parameter int PARAM_BURST_MAX = 16,
   parameter int PARAM_FIFO_LOG2 = 5
) (
   input  logic        i_wire_clock,
   input  logic        i_wire_resetn,
   input  logic        i_wire_start,
   input  logic [31:0] i_wire_address,
   input  logic [31:0] i_wire_length,
   output logic        o_wire_done,
   output logic        o_wire_error,
   output logic [2:0]  o_wire_error_type,
   output logic [31:0] o_wire_data,
   output logic        o_wire_data_valid,
   input  logic        i_wire_data_next,
   output logic [0:0]  o_wire_M_AXI_ARID,
   output logic [31:0] o_wire_M_AXI_ARADDR,
   output logic [7:0]  o_wire_M_AXI_ARLEN,
   output logic [2:0]  o_wire_M_AXI_ARSIZE,
   output logic [1:0]  o_wire_M_AXI_ARBURST,
   output logic        o_wire_M_AXI_ARLOCK,
   output logic [3:0]  o_wire_M_AXI_ARCACHE,
   output logic [2:0]  o_wire_M_AXI_ARPROT,
   output logic [3:0]  o_wire_M_AXI_ARQOS,
   output logic        o_wire_M_AXI_ARVALID,
   input  logic        i_wire_M_AXI_ARREADY,
   input  logic [0:0]  i_wire_M_AXI_RID,
   input  logic [31:0] i_wire_M_AXI_RDATA,
   input  logic [1:0]  i_wire_M_AXI_RRESP,
   input  logic        i_wire_M_AXI_RLAST,
   input  logic        i_wire_M_AXI_RVALID,
   output logic        o_wire_M_AXI_RREADY
);

   localparam logic [8:0] BURST_MAX_C = 9'(PARAM_BURST_MAX);
   localparam logic [PARAM_FIFO_LOG2:0] DEPTH_C = {1'b1, {PARAM_FIFO_LOG2{1'b0}}};

   gpu_state_t state_r;
   gpu_state_t state_next_s;

   logic [31:0] address_r;
   logic [31:0] length_r;
   logic [31:0] offset_r;
   logic [31:0] remaining_r;
   logic [31:0] cur_addr_r;
   logic [8:0]  boundary_r;
   logic [8:0]  burst_r;
   logic [8:0]  beat_cnt_r;
   logic [31:0] araddr_r;
   logic [7:0]  arlen_r;

   logic [31:0] cur_addr_s;
   logic [8:0]  cap_s;
   logic [8:0]  burst_s;
   logic [8:0]  burst_m1_s;
   logic        burst_fits_s;
   logic        last_beat_s;
   logic        xfer_done_s;
   logic        beat_ok_s;
   logic        wd_expired_s;

   logic                       fifo_push_s;
   logic                       fifo_pop_s;
   logic [31:0]                fifo_data_s;
   logic                       fifo_full_s;
   logic                       fifo_empty_s;
   logic [PARAM_FIFO_LOG2:0]   fifo_count_s;
   logic [PARAM_FIFO_LOG2:0]   free_s;
   logic                       unused_s;

   // ------------------------------------------------------------------
   // Burst sizing: min(remaining, distance to 1 KB boundary, burst cap)
   // ------------------------------------------------------------------
   assign cur_addr_s   = address_r + {offset_r[29:0], 2'b00};
   assign cap_s        = (BURST_MAX_C < boundary_r) ? BURST_MAX_C : boundary_r;
   assign burst_s      = (remaining_r < {23'd0, cap_s}) ? remaining_r[8:0] : cap_s;
   assign burst_m1_s   = burst_s - 9'd1;
   assign free_s       = DEPTH_C - fifo_count_s;
   assign burst_fits_s = ({23'd0, burst_s} <= 32'(free_s));
   assign last_beat_s  = (beat_cnt_r == (burst_r - 9'd1));
   assign xfer_done_s  = ((offset_r + {23'd0, burst_r}) >= length_r);
   assign beat_ok_s    = !i_wire_M_AXI_RRESP[1] && (i_wire_M_AXI_RLAST == last_beat_s);

   // ------------------------------------------------------------------
   // Stall watchdog
   // ------------------------------------------------------------------
`ifdef PAINTERENGINE_GPU_READER_TIMEOUT_EN
   logic [15:0] wd_r;
   logic        stall_s;

   assign stall_s = ((state_r == ST_ADDR) && !i_wire_M_AXI_ARREADY) ||
                    ((state_r == ST_DATA) && !i_wire_M_AXI_RVALID);
   assign wd_expired_s = stall_s && (wd_r == (TIMEOUT_LIMIT - 16'd1));

   // Count consecutive stalled cycles; any handshake or state change clears it.
   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         wd_r <= 16'd0;
      end else if (stall_s) begin
         wd_r <= wd_r + 16'd1;
      end else begin
         wd_r <= 16'd0;
      end
   end
`else
   assign wd_expired_s = 1'b0;
`endif

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------

   // State register.
   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decision.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE, ST_DONE, ST_ALIGN_ERR, ST_LEN_ERR, ST_AR_ERR,
         ST_R_ERR, ST_RESP_ERR, ST_LAST_ERR: begin
            if (i_wire_start) begin
               state_next_s = ST_CHECK;
            end else begin
               state_next_s = state_r;
            end
         end
         ST_CHECK: begin
            if (address_r[1:0] != 2'b00) begin
               state_next_s = ST_ALIGN_ERR;
            end else if (length_r == 32'd0) begin
               state_next_s = ST_LEN_ERR;
            end else begin
               state_next_s = ST_CALC;
            end
         end
         ST_CALC: begin
            state_next_s = ST_CALC2;
         end
         ST_CALC2: begin
            if (burst_fits_s) begin
               state_next_s = ST_ADDR;
            end else begin
               state_next_s = ST_CALC2;
            end
         end
         ST_ADDR: begin
            if (i_wire_M_AXI_ARREADY) begin
               state_next_s = ST_DATA;
            end else if (wd_expired_s) begin
               state_next_s = ST_AR_ERR;
            end else begin
               state_next_s = ST_ADDR;
            end
         end
         ST_DATA: begin
            if (i_wire_M_AXI_RVALID) begin
               if (i_wire_M_AXI_RRESP[1]) begin
                  state_next_s = ST_RESP_ERR;
               end else if (i_wire_M_AXI_RLAST != last_beat_s) begin
                  state_next_s = ST_LAST_ERR;
               end else if (last_beat_s) begin
                  state_next_s = xfer_done_s ? ST_DRAIN : ST_CALC;
               end else begin
                  state_next_s = ST_DATA;
               end
            end else if (wd_expired_s) begin
               state_next_s = ST_R_ERR;
            end else begin
               state_next_s = ST_DATA;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty_s) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_DRAIN;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Outputs decoded from the registered state.
   always_comb begin
      o_wire_M_AXI_ARVALID = (state_r == ST_ADDR);
      o_wire_M_AXI_RREADY  = (state_r == ST_DATA);
      o_wire_done          = (state_r == ST_DONE);
      o_wire_error         = state_is_error(state_r);
      case (state_r)
         ST_ALIGN_ERR: o_wire_error_type = ERR_ALIGN;
         ST_LEN_ERR:   o_wire_error_type = ERR_LEN;
         ST_AR_ERR:    o_wire_error_type = ERR_AR;
         ST_R_ERR:     o_wire_error_type = ERR_R;
         ST_RESP_ERR:  o_wire_error_type = ERR_RESP;
         ST_LAST_ERR:  o_wire_error_type = ERR_LAST;
         default:      o_wire_error_type = ERR_NONE;
      endcase
   end

   // ------------------------------------------------------------------
   // Transfer datapath
   // ------------------------------------------------------------------

   // Job latch, burst sizing pipeline, AR payload and beat counting.
   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         address_r   <= 32'd0;
         length_r    <= 32'd0;
         offset_r    <= 32'd0;
         remaining_r <= 32'd0;
         cur_addr_r  <= 32'd0;
         boundary_r  <= 9'd0;
         burst_r     <= 9'd0;
         beat_cnt_r  <= 9'd0;
         araddr_r    <= 32'd0;
         arlen_r     <= 8'd0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE, ST_ALIGN_ERR, ST_LEN_ERR, ST_AR_ERR,
            ST_R_ERR, ST_RESP_ERR, ST_LAST_ERR: begin
               if (i_wire_start) begin
                  address_r <= i_wire_address;
                  length_r  <= i_wire_length;
                  offset_r  <= 32'd0;
               end
            end
            ST_CALC: begin
               remaining_r <= length_r - offset_r;
               boundary_r  <= 9'd256 - {1'b0, cur_addr_s[9:2]};
               cur_addr_r  <= cur_addr_s;
            end
            ST_CALC2: begin
               // AR payload is frozen here so it is stable for all of ADDR.
               if (burst_fits_s) begin
                  araddr_r <= cur_addr_r;
                  arlen_r  <= burst_m1_s[7:0];
                  burst_r  <= burst_s;
               end
            end
            ST_ADDR: begin
               if (i_wire_M_AXI_ARREADY) begin
                  beat_cnt_r <= 9'd0;
               end
            end
            ST_DATA: begin
               if (i_wire_M_AXI_RVALID) begin
                  beat_cnt_r <= beat_cnt_r + 9'd1;
                  if (beat_ok_s && last_beat_s) begin
                     offset_r <= offset_r + {23'd0, burst_r};
                  end
               end
            end
            default: begin
               beat_cnt_r <= beat_cnt_r;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Beat buffer
   // ------------------------------------------------------------------
   assign fifo_push_s = (state_r == ST_DATA) && i_wire_M_AXI_RVALID;
   assign fifo_pop_s  = i_wire_data_next && o_wire_data_valid;

   painterengine_gpu_sync_fifo #(
      .WIDTH (32),
      .LOG2  (PARAM_FIFO_LOG2)
   ) u_fifo (
      .i_wire_clock     (i_wire_clock),
      .i_wire_resetn    (i_wire_resetn),
      .i_wire_push      (fifo_push_s),
      .i_wire_push_data (i_wire_M_AXI_RDATA),
      .i_wire_pop       (fifo_pop_s),
      .o_wire_pop_data  (fifo_data_s),
      .o_wire_full      (fifo_full_s),
      .o_wire_empty     (fifo_empty_s),
      .o_wire_count     (fifo_count_s)
   );

   assign o_wire_data       = fifo_data_s;
   assign o_wire_data_valid = !fifo_empty_s;

   // ------------------------------------------------------------------
   // AXI read-address channel
   // ------------------------------------------------------------------
   assign o_wire_M_AXI_ARID    = 1'b0;
   assign o_wire_M_AXI_ARADDR  = araddr_r;
   assign o_wire_M_AXI_ARLEN   = arlen_r;
   assign o_wire_M_AXI_ARSIZE  = AXI_SIZE_4B;
   assign o_wire_M_AXI_ARBURST = AXI_BURST_INCR;
   assign o_wire_M_AXI_ARLOCK  = 1'b0;
   assign o_wire_M_AXI_ARCACHE = AXI_CACHE_MOD;
   assign o_wire_M_AXI_ARPROT  = 3'b000;
   assign o_wire_M_AXI_ARQOS   = 4'b0000;

   // Full can never be reached mid-burst and RID is single-valued.
   assign unused_s = ^{fifo_full_s, i_wire_M_AXI_RID};

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Directed bench for painterengine_gpu_dma_reader with a behavioural AXI
// read slave (data word = 0xD0000000 + byte address) and a stream consumer.
module tb_painterengine_gpu_dma_reader;

   logic        clk;
   logic        rstn;
   logic        start;
   logic [31:0] addr;
   logic [31:0] len;
   logic        done;
   logic        error;
   logic [2:0]  etype;
   logic [31:0] data;
   logic        valid;
   logic        next;
   logic [0:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic [3:0]  arqos;
   logic        arvalid;
   logic        arready;
   logic [0:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   // bench knobs
   logic arready_en;
   logic rvalid_en;
   logic next_en;
   int   err_beat;
   int   last_err_beat;

   // logs / slave state
   logic [31:0] ar_addr_q[$];
   int          ar_len_q[$];
   logic [31:0] pend_addr[$];
   int          pend_len[$];
   logic [31:0] rx[$];
   int          beat;
   int          arvalid_cycles;
   logic        rready_seen;

   int tests_run;
   int fails;

   painterengine_gpu_dma_reader dut (
      .i_wire_clock         (clk),
      .i_wire_resetn        (rstn),
      .i_wire_start         (start),
      .i_wire_address       (addr),
      .i_wire_length        (len),
      .o_wire_done          (done),
      .o_wire_error         (error),
      .o_wire_error_type    (etype),
      .o_wire_data          (data),
      .o_wire_data_valid    (valid),
      .i_wire_data_next     (next),
      .o_wire_M_AXI_ARID    (arid),
      .o_wire_M_AXI_ARADDR  (araddr),
      .o_wire_M_AXI_ARLEN   (arlen),
      .o_wire_M_AXI_ARSIZE  (arsize),
      .o_wire_M_AXI_ARBURST (arburst),
      .o_wire_M_AXI_ARLOCK  (arlock),
      .o_wire_M_AXI_ARCACHE (arcache),
      .o_wire_M_AXI_ARPROT  (arprot),
      .o_wire_M_AXI_ARQOS   (arqos),
      .o_wire_M_AXI_ARVALID (arvalid),
      .i_wire_M_AXI_ARREADY (arready),
      .i_wire_M_AXI_RID     (rid),
      .i_wire_M_AXI_RDATA   (rdata),
      .i_wire_M_AXI_RRESP   (rresp),
      .i_wire_M_AXI_RLAST   (rlast),
      .i_wire_M_AXI_RVALID  (rvalid),
      .o_wire_M_AXI_RREADY  (rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // AXI read slave: everything decided on the falling edge.
   initial begin
      arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
      rlast = 1'b0; rid = 1'b0; rready_seen = 1'b0; beat = 0; arvalid_cycles = 0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            pend_addr.delete(); pend_len.delete(); beat = 0;
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = 32'd0;
            rready_seen = 1'b0; arready = arready_en;
         end else begin
            if (rvalid && rready_seen) begin
               if (beat == pend_len[0]) begin
                  void'(pend_addr.pop_front()); void'(pend_len.pop_front()); beat = 0;
               end else begin
                  beat++;
               end
            end
            if (rvalid_en && pend_addr.size() > 0) begin
               rvalid = 1'b1;
               rdata  = 32'hD000_0000 + pend_addr[0] + 32'(4 * beat);
               rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
               rlast  = (beat == last_err_beat) ? 1'b1 : (beat == pend_len[0]);
            end else begin
               rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
            end
            rready_seen = rready;
            arready = arready_en;
            if (arvalid) arvalid_cycles++;
            if (arvalid && arready) begin
               pend_addr.push_back(araddr); pend_len.push_back(int'(arlen));
               ar_addr_q.push_back(araddr); ar_len_q.push_back(int'(arlen));
            end
         end
      end
   end

   // Stream consumer: a pop happens at the next rising edge when valid && next.
   initial begin
      next = 1'b0;
      forever begin
         @(negedge clk);
         next = next_en;
         if (rstn && valid && next) rx.push_back(data);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [31:0] a, input logic [31:0] l);
      @(negedge clk);
      addr = a; len = l; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end(input string tag, input int budget);
      int n;
      n = 0;
      while (!(done || error) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(done || error), 32'd1);
   endtask

   task automatic clear_logs();
      ar_addr_q.delete(); ar_len_q.delete(); rx.delete(); arvalid_cycles = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      #600000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      int bad;
      tests_run = 0; fails = 0;
      start = 1'b0; addr = 32'd0; len = 32'd0; rstn = 1'b0;
      arready_en = 1'b1; rvalid_en = 1'b1; next_en = 1'b1;
      err_beat = -1; last_err_beat = -1;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_arvalid", 32'(arvalid), 32'd0);
      check("rst_rready",  32'(rready),  32'd0);
      check("rst_araddr",  araddr,       32'd0);
      check("rst_arlen",   32'(arlen),   32'd0);
      check("rst_valid",   32'(valid),   32'd0);
      check("rst_data",    data,         32'd0);
      check("rst_flags",   32'({done, error, etype}), 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // T1: single 8-beat burst, start-to-ARVALID latency
      clear_logs();
      do_start(32'h1000, 32'd8);
      k = 1;
      while (!arvalid && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("t1_ar_latency", 32'(k), 32'd4);
      check("t1_ar_consts", 32'({arid, arsize, arburst, arlock, arcache, arprot, arqos}),
            32'({1'b0, 3'b010, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000}));
      wait_end("t1_end", 200);
      check("t1_done", 32'({done, error}), 32'b10);
      check("t1_ar_count", 32'(ar_addr_q.size()), 32'd1);
      check("t1_araddr", ar_addr_q[0], 32'h1000);
      check("t1_arlen", 32'(ar_len_q[0]), 32'd7);
      check("t1_words", 32'(rx.size()), 32'd8);
      for (int i = 0; i < rx.size(); i++)
         check("t1_word", rx[i], 32'hD000_1000 + 32'(4 * i));

      // T2: 1 KB boundary split, started from DONE
      clear_logs();
      do_start(32'h13F8, 32'd20);
      wait_end("t2_end", 300);
      check("t2_done", 32'(done), 32'd1);
      check("t2_ar_count", 32'(ar_addr_q.size()), 32'd3);
      check("t2_ar0", {ar_addr_q[0][23:0], 8'(ar_len_q[0])}, 32'h0013F8_01);
      check("t2_ar1", {ar_addr_q[1][23:0], 8'(ar_len_q[1])}, 32'h001400_0F);
      check("t2_ar2", {ar_addr_q[2][23:0], 8'(ar_len_q[2])}, 32'h001440_01);
      check("t2_words", 32'(rx.size()), 32'd20);
      bad = 0;
      for (int i = 0; i < rx.size(); i++)
         if (rx[i] !== 32'hD000_13F8 + 32'(4 * i)) bad++;
      check("t2_order", 32'(bad), 32'd0);

      // T3: back-pressure limits buffering to the FIFO depth
      clear_logs();
      next_en = 1'b0;
      do_start(32'h2000, 32'd64);
      repeat (200) @(negedge clk);
      check("t3_held_ar_count", 32'(ar_addr_q.size()), 32'd2);
      check("t3_held_state", 32'({valid, done, error}), 32'b100);
      next_en = 1'b1;
      wait_end("t3_end", 3000);
      check("t3_done", 32'(done), 32'd1);
      check("t3_ar_count", 32'(ar_addr_q.size()), 32'd4);
      check("t3_words", 32'(rx.size()), 32'd64);
      bad = 0;
      for (int i = 0; i < rx.size(); i++)
         if (rx[i] !== 32'hD000_2000 + 32'(4 * i)) bad++;
      check("t3_order", 32'(bad), 32'd0);

      // T4: alignment error, then zero length started from the error state
      clear_logs();
      do_start(32'h1002, 32'd4);
      wait_end("t4a_end", 50);
      check("t4a_error", 32'({error, etype}), 32'b1_001);
      check("t4a_no_arvalid", 32'(arvalid_cycles), 32'd0);
      do_start(32'h1000, 32'd0);
      wait_end("t4b_end", 50);
      check("t4b_error", 32'({error, etype}), 32'b1_010);
      check("t4b_no_arvalid", 32'(arvalid_cycles), 32'd0);

      // T5: RRESP error on the third beat
      clear_logs();
      err_beat = 2;
      do_start(32'h3000, 32'd4);
      wait_end("t5_end", 100);
      check("t5_error", 32'({error, etype}), 32'b1_101);
      check("t5_rready", 32'(rready), 32'd0);
      repeat (5) @(negedge clk);
      check("t5_words", 32'(rx.size()), 32'd3);
      check("t5_err_word", rx[2], 32'hD000_3008);
      err_beat = -1;

      // T6: early RLAST on beat 2 of a 4-beat burst
      do_reset();
      clear_logs();
      last_err_beat = 1;
      do_start(32'h3000, 32'd4);
      wait_end("t6_end", 100);
      check("t6_error", 32'({error, etype}), 32'b1_110);
      last_err_beat = -1;

      // T7: asynchronous reset in the middle of DATA
      do_reset();
      clear_logs();
      next_en = 1'b0;
      do_start(32'h4000, 32'd16);
      k = 0;
      while (!(valid && rready) && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("t7_in_data", 32'(valid && rready), 32'd1);
      rstn = 1'b0;
      #1;
      check("t7_rst_stream", 32'({valid, rready, arvalid}), 32'd0);
      check("t7_rst_data", data, 32'd0);
      check("t7_rst_ar", {araddr[23:0], arlen}, 32'd0);
      check("t7_rst_flags", 32'({done, error, etype}), 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      next_en = 1'b1;

      // T8: AR / R stall handling
      clear_logs();
      arready_en = 1'b0;
      do_start(32'h1000, 32'd4);
`ifdef PAINTERENGINE_GPU_READER_TIMEOUT_EN
      wait_end("t8_ar_end", 400);
      check("t8_ar_error", 32'({error, etype}), 32'b1_011);
      check("t8_ar_stall_cycles", 32'(arvalid_cycles), 32'd256);
      arready_en = 1'b1;
      rvalid_en = 1'b0;
      do_start(32'h1000, 32'd4);
      wait_end("t8_r_end", 400);
      check("t8_r_error", 32'({error, etype}), 32'b1_100);
      rvalid_en = 1'b1;
`else
      repeat (400) @(negedge clk);
      check("t8_waiting", 32'({arvalid, error}), 32'b10);
      arready_en = 1'b1;
      wait_end("t8_end", 100);
      check("t8_done", 32'({done, error}), 32'b10);
      check("t8_words", 32'(rx.size()), 32'd4);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
